// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - round sequencer for the sprite game: start, aim, shot, end and win score
module game_round_controller #(
  parameter int END_FRAMES          = 60,
  parameter int SHOT_TIMEOUT_FRAMES = 255,
  parameter int FRAME_CNT_WIDTH     = 8,
  parameter int SCORE_WIDTH         = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  input  logic                   frame_end,
  input  logic                   collision,
  input  logic                   target_out,
  input  logic                   torpedo_out,
  output logic                   sprite_start,
  output logic                   sprite_enable,
  output logic                   launch,
  output logic                   end_of_game,
  output logic                   game_won,
  output logic [SCORE_WIDTH-1:0] score
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_AIM   = 3'd2,
    ST_SHOT  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam logic [FRAME_CNT_WIDTH-1:0] END_CNT  = FRAME_CNT_WIDTH'(END_FRAMES);
  localparam logic [FRAME_CNT_WIDTH-1:0] SHOT_CNT = FRAME_CNT_WIDTH'(SHOT_TIMEOUT_FRAMES);

  state_t                     state_q;
  logic                       key_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_d;
  logic [SCORE_WIDTH-1:0]     score_q;
  logic [SCORE_WIDTH-1:0]     score_d;
  logic                       key_rise;
  logic                       sprite_start_q, sprite_enable_q, launch_q;
  logic                       end_of_game_q, game_won_q;

  always_comb begin
    key_rise    = key & ~key_q;
    frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
    // Score saturates at all-ones rather than wrapping back to zero
    score_d     = (score_q == '1) ? score_q : score_q + SCORE_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      key_q           <= 1'b0;
      frame_cnt_q     <= '0;
      score_q         <= '0;
      sprite_start_q  <= 1'b0;
      sprite_enable_q <= 1'b0;
      launch_q        <= 1'b0;
      end_of_game_q   <= 1'b0;
      game_won_q      <= 1'b0;
    end else begin
      key_q          <= key;
      sprite_start_q <= 1'b0;
      launch_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_end) begin
            state_q        <= ST_START;
            sprite_start_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q         <= ST_AIM;
          frame_cnt_q     <= '0;
          sprite_enable_q <= 1'b1;
        end
        ST_AIM: begin
          if (target_out) begin
            state_q         <= ST_END;
            frame_cnt_q     <= '0;
            sprite_enable_q <= 1'b0;
            end_of_game_q   <= 1'b1;
            game_won_q      <= 1'b0;
          end else if (key_rise) begin
            state_q     <= ST_SHOT;
            frame_cnt_q <= '0;
            launch_q    <= 1'b1;
          end
        end
        ST_SHOT: begin
          if (collision) begin
            state_q         <= ST_END;
            frame_cnt_q     <= '0;
            sprite_enable_q <= 1'b0;
            end_of_game_q   <= 1'b1;
            game_won_q      <= 1'b1;
            score_q         <= score_d;
          end else if (target_out || torpedo_out || (frame_end && frame_cnt_d == SHOT_CNT)) begin
            state_q         <= ST_END;
            frame_cnt_q     <= '0;
            sprite_enable_q <= 1'b0;
            end_of_game_q   <= 1'b1;
            game_won_q      <= 1'b0;
          end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_d;
          end
        end
        ST_END: begin
          if (frame_end) begin
            if (frame_cnt_d == END_CNT) begin
              state_q        <= ST_START;
              sprite_start_q <= 1'b1;
              end_of_game_q  <= 1'b0;
              game_won_q     <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sprite_start  = sprite_start_q;
  assign sprite_enable = sprite_enable_q;
  assign launch        = launch_q;
  assign end_of_game   = end_of_game_q;
  assign game_won      = game_won_q;
  assign score         = score_q;

endmodule

// File: tb/tb_game_round_controller.sv
// tb/tb_game_round_controller.sv - bench for game_round_controller with a round-level reference model
module tb_game_round_controller;

  localparam int END_N   = 60;
  localparam int SHOT_N  = 255;
  localparam int SCORE_M = 15;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_AIM   = 2;
  localparam int P_SHOT  = 3;
  localparam int P_END   = 4;

  logic       clk = 1'b0;
  logic       reset, key, frame_end, collision, target_out, torpedo_out;
  logic       sprite_start, sprite_enable, launch, end_of_game, game_won;
  logic [3:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase, m_frames, m_score;
  bit m_won, m_keyh, m_launch;

  always #5 clk = ~clk;

  game_round_controller #(
    .END_FRAMES(END_N), .SHOT_TIMEOUT_FRAMES(SHOT_N), .FRAME_CNT_WIDTH(8), .SCORE_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .frame_end(frame_end), .collision(collision),
    .target_out(target_out), .torpedo_out(torpedo_out), .sprite_start(sprite_start),
    .sprite_enable(sprite_enable), .launch(launch), .end_of_game(end_of_game),
    .game_won(game_won), .score(score)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-level reference: which phase the game is in and how many frames it has seen there
  task automatic model_step();
    bit rise;
    m_launch = 1'b0;
    if (!reset) begin
      m_phase = P_IDLE; m_frames = 0; m_won = 1'b0; m_score = 0; m_keyh = 1'b0;
      return;
    end
    rise   = key && !m_keyh;
    m_keyh = key;
    if (m_phase == P_IDLE) begin
      if (frame_end) m_phase = P_START;
    end else if (m_phase == P_START) begin
      m_phase = P_AIM; m_frames = 0;
    end else if (m_phase == P_AIM) begin
      if (target_out) begin
        m_phase = P_END; m_won = 1'b0; m_frames = 0;
      end else if (rise) begin
        m_phase = P_SHOT; m_frames = 0; m_launch = 1'b1;
      end
    end else if (m_phase == P_SHOT) begin
      if (collision) begin
        m_phase = P_END; m_won = 1'b1; m_frames = 0;
        m_score = (m_score < SCORE_M) ? m_score + 1 : SCORE_M;
      end else if (target_out || torpedo_out) begin
        m_phase = P_END; m_won = 1'b0; m_frames = 0;
      end else if (frame_end) begin
        m_frames++;
        if (m_frames == SHOT_N) begin
          m_phase = P_END; m_won = 1'b0; m_frames = 0;
        end
      end
    end else begin
      if (frame_end) begin
        m_frames++;
        if (m_frames == END_N) begin
          m_phase = P_START; m_won = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("sprite_start", sprite_start, int'(m_phase == P_START));
    check("sprite_enable", sprite_enable, int'(m_phase == P_AIM || m_phase == P_SHOT));
    check("launch", launch, int'(m_launch));
    check("end_of_game", end_of_game, int'(m_phase == P_END));
    check("game_won", game_won, int'(m_phase == P_END && m_won));
    check("score", score, m_score);
  endtask

  task automatic finish_end(input bit pin);
    for (int i = 0; i < END_N; i++) begin
      frame_end = 1'b1;
      cyc();
      if (pin && i == END_N - 1) begin
        check("restart_pulse", sprite_start, 1);
        check("restart_eog", end_of_game, 0);
      end
      frame_end = 1'b0;
      cyc();
    end
  endtask

  task automatic win_round();
    key = 1'b1; cyc();
    key = 1'b0; collision = 1'b1; cyc();
    collision = 1'b0;
    finish_end(1'b0);
  endtask

  initial begin
    int launches;
    reset = 1'b0; key = 1'b0; frame_end = 1'b0;
    collision = 1'b0; target_out = 1'b0; torpedo_out = 1'b0;
    cyc(); cyc();
    check("reset_score", score, 0);
    check("reset_eog", end_of_game, 0);

    reset = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    check("idle_enable", sprite_enable, 0);
    check("idle_start", sprite_start, 0);

    frame_end = 1'b1; cyc();
    check("start_pulse", sprite_start, 1);
    frame_end = 1'b0; cyc();
    check("start_once", sprite_start, 0);
    check("aim_enable", sprite_enable, 1);

    launches = 0;
    key = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      launches += int'(launch);
    end
    check("launch_count", launches, 1);
    key = 1'b0; collision = 1'b1; cyc();
    collision = 1'b0;
    check("win_flag", game_won, 1);
    check("win_score", score, 1);
    finish_end(1'b1);

    key = 1'b1; cyc();
    key = 1'b0; collision = 1'b1; torpedo_out = 1'b1; cyc();
    collision = 1'b0; torpedo_out = 1'b0;
    check("both_win", game_won, 1);
    check("both_score", score, 2);
    finish_end(1'b0);

    key = 1'b1; cyc();
    key = 1'b0;
    for (int i = 0; i < SHOT_N; i++) begin
      frame_end = 1'b1; cyc();
      frame_end = 1'b0; cyc();
    end
    check("timeout_eog", end_of_game, 1);
    check("timeout_won", game_won, 0);
    check("timeout_score", score, 2);
    finish_end(1'b0);

    launches = 0;
    target_out = 1'b1; key = 1'b1; cyc();
    launches += int'(launch);
    target_out = 1'b0; key = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      launches += int'(launch);
    end
    check("tout_nolaunch", launches, 0);
    check("tout_lose", game_won, 0);
    check("tout_eog", end_of_game, 1);
    finish_end(1'b0);

    for (int r = 0; r < 20; r++) win_round();
    check("saturate", score, 15);

    key = 1'b1; cyc();
    key = 1'b0; cyc();
    reset = 1'b0; cyc();
    check("rst_enable", sprite_enable, 0);
    check("rst_score", score, 0);
    reset = 1'b1;

    for (int i = 0; i < 6000; i++) begin
      reset       = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 5) == 0) key = ~key;
      frame_end   = ($urandom_range(0, 3) == 0);
      collision   = ($urandom_range(0, 24) == 0);
      target_out  = ($urandom_range(0, 59) == 0);
      torpedo_out = ($urandom_range(0, 59) == 0);
      cyc();
      if (sprite_start && launch) check("start_launch_excl", 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
